// File: rtl/seq_gen_arbiter_if.sv
// Bundles the requester-side and sequence_gen-side signals of the arbiter.
// master = arbiter side, slave = requesters plus the sequence_gen datapath.
interface seq_gen_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int FIB_ORDER  = 16
);
    // reqN is a valid held high until ackN pulses; ackN is a one-cycle completion
    // strobe and the requester drops reqN at the same edge it sees ackN.
    logic                  req0, req1;
    logic                  mode0, mode1;
    logic [FIB_ORDER-1:0]  order0, order1;
    logic [DATA_WIDTH-1:0] data0, data1;
    logic                  ack0, ack1;
    logic [DATA_WIDTH-1:0] result;
    logic [1:0]            status;
    logic                  busy;
    logic                  load, fibonacci, triangle, clear;
    logic [FIB_ORDER-1:0]  order;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  done, error, overflow;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        input  req0, req1, mode0, mode1, order0, order1, data0, data1,
        input  done, error, overflow, data_out,
        output ack0, ack1, result, status, busy,
        output load, fibonacci, triangle, clear, order, data_in
    );

    modport slave (
        output req0, req1, mode0, mode1, order0, order1, data0, data1,
        output done, error, overflow, data_out,
        input  ack0, ack1, result, status, busy,
        input  load, fibonacci, triangle, clear, order, data_in
    );
endinterface

// File: rtl/seq_gen_arbiter.sv
// Round-robin arbiter that owns the sequence_gen datapath for one job at a time,
// handling done/error/overflow/timeout and the clear sequence before responding.
module seq_gen_arbiter #(
    parameter int DATA_WIDTH     = 64,
    parameter int FIB_ORDER      = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CLEAR_CYCLES   = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    seq_gen_arbiter_if.master  bus,
    output logic [2:0]         state_o
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_BUSY     = 3'd1,
        S_OVF_WAIT = 3'd2,
        S_CLEAR    = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    // One counter serves both the BUSY timeout and the CLEAR hold length.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > CLEAR_CYCLES) ? TIMEOUT_CYCLES : CLEAR_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  ptr_q, ptr_d;
    logic                  owner_q, owner_d;
    logic                  mode_q, mode_d;
    logic [FIB_ORDER-1:0]  order_q, order_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [1:0]            status_q, status_d;
    logic                  grant1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            mode_q   <= 1'b0;
            order_q  <= '0;
            data_q   <= '0;
            result_q <= '0;
            status_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            mode_q   <= mode_d;
            order_q  <= order_d;
            data_q   <= data_d;
            result_q <= result_d;
            status_q <= status_d;
        end
    end

    // A lone request always wins; on contention the pointer picks the winner.
    assign grant1 = bus.req1 & (~bus.req0 | ptr_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        mode_d   = mode_q;
        order_d  = order_q;
        data_d   = data_q;
        result_d = result_q;
        status_d = status_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_d = grant1;
                    mode_d  = grant1 ? bus.mode1  : bus.mode0;
                    order_d = grant1 ? bus.order1 : bus.order0;
                    data_d  = grant1 ? bus.data1  : bus.data0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (bus.error) begin
                    result_d = bus.data_out;
                    status_d = 2'b01;
                    cnt_d    = '0;
                    state_d  = S_CLEAR;
                end else if (bus.overflow) begin
                    state_d = S_OVF_WAIT;
                end else if (bus.done) begin
                    result_d = bus.data_out;
                    status_d = 2'b00;
                    state_d  = S_RESP;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    result_d = '0;
                    status_d = 2'b11;
                    cnt_d    = '0;
                    state_d  = S_CLEAR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_OVF_WAIT: begin
                // Overflow data settles one cycle after the flag.
                result_d = bus.data_out;
                status_d = 2'b10;
                cnt_d    = '0;
                state_d  = S_CLEAR;
            end
            S_CLEAR: begin
                if (cnt_q == CW'(CLEAR_CYCLES - 1)) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                ptr_d   = ~owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.load      = 1'b0;
        bus.fibonacci = 1'b0;
        bus.triangle  = 1'b0;
        bus.clear     = 1'b0;
        bus.order     = '0;
        bus.data_in   = '0;
        bus.ack0      = 1'b0;
        bus.ack1      = 1'b0;
        bus.busy      = (state_q != S_IDLE);
        bus.result    = result_q;
        bus.status    = status_q;
        state_o       = state_q;
        case (state_q)
            S_BUSY, S_OVF_WAIT: begin
                bus.load      = 1'b1;
                bus.fibonacci = ~mode_q;
                bus.triangle  = mode_q;
                bus.order     = order_q;
                bus.data_in   = data_q;
            end
            S_CLEAR: bus.clear = 1'b1;
            S_RESP: begin
                bus.ack0 = ~owner_q;
                bus.ack1 = owner_q;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/seq_gen_arbiter.md
# seq_gen_arbiter

Shared-access controller for the `sequence_gen` datapath. Two requester ports each submit a sequence job: Fibonacci or triangle mode, an order, and an initial value. The block grants the datapath round-robin and drives the `sequence_gen` load/mode/order/data_in pins for the job's duration. It collects done/error/overflow, runs the clear sequence after error, overflow or hang, and returns result plus status to the owning requester. It sits between the requester logic and `sequence_gen`, replacing direct stimulus on the datapath pins.

## Interface
- `DATA_WIDTH`, 64, data_in/data_out/result width
- `FIB_ORDER`, 16, order width
- `TIMEOUT_CYCLES`, 1024, max BUSY cycles before forced abort (>=2)
- `CLEAR_CYCLES`, 2, cycles `clear` is held (>=1)
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req0`/`req1`  in  1  job request; held until matching ack, dropped at the edge where ack is seen
- `mode0`/`mode1`  in  1  0 = Fibonacci, 1 = triangle
- `order0`/`order1`  in  FIB_ORDER  sequence order
- `data0`/`data1`  in  DATA_WIDTH  initial value
- `ack0`/`ack1`  out  1  one-cycle completion pulse to owner
- `result`  out  DATA_WIDTH  captured data_out; valid while an ack is high, held otherwise
- `status`  out  2  00 done, 01 error, 10 overflow, 11 timeout; valid with ack
- `busy`  out  1  high in any state but IDLE
- `load`, `fibonacci`, `triangle`, `clear`  out  1  to sequence_gen
- `order`  out  FIB_ORDER  to sequence_gen
- `data_in`  out  DATA_WIDTH  to sequence_gen
- `done`, `error`, `overflow`  in  1  from sequence_gen
- `data_out`  in  DATA_WIDTH  from sequence_gen

## Operation
- FSM states: IDLE, BUSY, OVF_WAIT, CLEAR, RESP.
- IDLE:
  - Any req high → arbitrate, latch the winner's mode/order/data and owner ID, start the cycle counter at 0, go to BUSY.
  - Round-robin: a pointer names the requester with priority. Reset value is 0 (req0).
  - In RESP the pointer moves to the non-owner.
  - A lone request wins regardless of the pointer.
- BUSY:
  - `load` = 1. `fibonacci` = !mode, `triangle` = mode. `order`/`data_in` = latched values, all held constant.
  - Flags are ignored in the first BUSY cycle (counter = 0).
  - From then on, at each edge:
    - error → capture data_out, status 01, go to CLEAR.
    - else overflow → go to OVF_WAIT.
    - else done → capture data_out, status 00, go to RESP.
    - else counter = TIMEOUT_CYCLES-1 → status 11, result 0, go to CLEAR.
    - else counter increments.
- OVF_WAIT:
  - One cycle; load and mode pins still driven.
  - data_out is captured at the end of this cycle, status 10, go to CLEAR.
- CLEAR:
  - `load` = 0, mode pins 0, `order`/`data_in` = 0, `clear` = 1 for exactly CLEAR_CYCLES cycles, then go to RESP.
- RESP:
  - All datapath outputs 0. `ack` of the owner = 1 for one cycle.
  - Update the pointer, go to IDLE.
  - The next grant is decided in the IDLE cycle that follows, so there is at least one idle cycle between jobs.
- Non-owner requests stay pending untouched during a job. Requester inputs changing after the latch have no effect.
- Flag priority on simultaneous assertion: error > overflow > done.

## Timing
- Reset (async assert, sync-released state): IDLE, pointer 0, counter 0.
  - All outputs 0, including `load`, `clear`, `ack0`/`ack1`, `busy`, `result` and `status`.
- Reset mid-job: immediate abort with no ack and no clear pulse. The job is lost; a still-high req is re-arbitrated after release.
- Request latency: req high in IDLE cycle t → `load` high from cycle t+1.
- Done path: done sampled at the end of BUSY cycle n → ack in cycle n+1. `load` falls the same edge ack rises.
- Error path: ack arrives CLEAR_CYCLES+1 cycles after the error edge.
- Overflow path: ack arrives CLEAR_CYCLES+2 cycles after the overflow edge.
- Timeout path: BUSY lasts exactly TIMEOUT_CYCLES cycles when no flag ever arrives.
- `result`/`status` hold their values until the next capture.

## Test plan
- **Single Fibonacci job.** req0, mode0=0, order0=10, data0=1; model asserts done with data_out=89 in the 12th BUSY cycle.
  - `load`/`fibonacci` high exactly 12 cycles with order=10, data_in=1.
  - Next cycle: ack0=1, result=89, status=00, ack1 stays 0.
- **Round-robin.** req0 and req1 both raised in the same cycle after reset, each job done after 3 cycles.
  - req0 is served first, then req1.
  - With both re-raised immediately, req0 then req1 again; a lone req1 during req0's job waits.
- **Error.** Triangle job on req1; error asserted in BUSY cycle 5 with data_out=0xDEAD.
  - `load` falls, `clear` high 2 cycles, then ack1 with status=01 and result=0xDEAD.
  - `triangle` was high during BUSY.
- **Overflow with late data.** overflow at cycle 7, data_out=0x10 that cycle and 0x20 the next.
  - result=0x20, status=10.
  - `load` high through OVF_WAIT, then clear for 2 cycles, then ack.
- **Timeout and flag priority.**
  - TIMEOUT_CYCLES=16, no flags: BUSY lasts 16 cycles, clear for 2, status=11, result=0.
  - A separate job with done, error and overflow raised together: status=01.
- **Reset mid-BUSY.** reset_n pulled low in BUSY cycle 4 with req1 pending.
  - All outputs 0 asynchronously, no ack.
  - After release, req0 (still high) is granted first (pointer 0), then req1.
